exe_stage: RTL and testbench
============================

Name: exe_stage

Overview:
- Execute stage of the 5-stage in-order scalar pipeline, directly downstream of the decode stage.
- Registers the decoded bundle, computes the 12-op ALU result and issues the data-SRAM request for loads and stores.
- Forwards the writeback-relevant fields to the memory stage under the same valid/allowin handshake used throughout the pipeline.

Parameters:
- None. Bus widths come from the shared header: DS_TO_ES_BUS_WD = 150, ES_TO_MS_BUS_WD = 71.

Ports:
clk  in  1  core clock
reset  in  1  synchronous active-high reset
ms_allowin  in  1  memory stage can accept this cycle
es_allowin  out  1  this stage can accept this cycle
ds_to_es_valid  in  1  decode holds a valid instruction
ds_to_es_bus  in  150  {alu_op[11:0], res_from_mem, src1_is_pc, src2_is_imm, gr_we, mem_we, dest[4:0], imm[31:0], rj_value[31:0], rkd_value[31:0], pc[31:0]}, MSB first
es_to_ms_valid  out  1  valid instruction offered to the memory stage
es_to_ms_bus  out  71  {res_from_mem, gr_we, dest[4:0], alu_result[31:0], pc[31:0]}, MSB first
data_sram_en  out  1  data SRAM access enable
data_sram_we  out  4  byte write enables
data_sram_addr  out  32  byte address
data_sram_wdata  out  32  store data

Behaviour:
- Only clock is clk. reset is synchronous, active-high.
- State:
  - es_valid register, reset value 0.
  - bus register (150 b), reset value 0.
- Handshake:
  - es_ready_go = 1 (single-cycle execute).
  - es_allowin = !es_valid || (es_ready_go && ms_allowin).
  - es_to_ms_valid = es_valid && es_ready_go.
- Register updates:
  - If es_allowin, es_valid <= ds_to_es_valid on the next clk edge.
  - If ds_to_es_valid && es_allowin, the bus register <= ds_to_es_bus.
  - Otherwise both registers hold. A stall therefore freezes contents, and all outputs stay stable while ms_allowin = 0.
- Operands:
  - src1 = src1_is_pc ? pc : rj_value.
  - src2 = src2_is_imm ? imm : rkd_value.
- ALU (alu_op is one-hot; an all-zero op gives result 0):
  - bit 0 add: src1 + src2, mod 2^32.
  - bit 1 sub: src1 - src2, mod 2^32.
  - bit 2 slt: signed compare, result 1 or 0.
  - bit 3 sltu: unsigned compare, result 1 or 0.
  - bit 4 and; bit 5 nor; bit 6 or; bit 7 xor.
  - bit 8 sll: src1 << src2[4:0].
  - bit 9 srl: src1 >> src2[4:0], logical.
  - bit 10 sra: src1 >> src2[4:0], arithmetic.
  - bit 11 lui: result = src2 (the immediate arrives pre-shifted).
  - Only src2[4:0] is used as the shift amount; upper bits are ignored.
- Purely combinational from the registered bundle to alu_result; latency is one cycle from acceptance to the es_to_ms offer.
- Data SRAM:
  - data_sram_en = es_valid && (res_from_mem || mem_we).
  - data_sram_we = (es_valid && mem_we) ? 4'hF : 4'h0.
  - data_sram_addr = alu_result.
  - data_sram_wdata = rkd_value.
  - Load data returns one cycle later and is consumed by the memory stage.
- No alignment check; the address is passed through unchanged.
- A store holds its request on the SRAM while stalled. The SRAM write is idempotent, so repeated cycles are acceptable.
- es_to_ms_bus is driven from the current registered fields even when es_valid = 0. Consumers must qualify it with es_to_ms_valid.
- Reset mid-operation: the instruction held in the stage is discarded and es_valid = 0 in the cycle after reset. data_sram_en and data_sram_we are 0 while reset is held (es_valid = 0).
- Simultaneous events:
  - Accept and drain in the same cycle (es_valid = 1, ms_allowin = 1, ds_to_es_valid = 1): the new bundle replaces the old; no bubble.
  - Drain with no input (ds_to_es_valid = 0, es_allowin = 1): es_valid <= 0.

Test Plan:
- Reset: reset = 1 for 2 cycles -> es_valid = 0, es_to_ms_valid = 0, data_sram_en = 0, data_sram_we = 0, es_allowin = 1.
- add.w:
  - Stimulus: alu_op = 0x001, rj = 0x7FFFFFFF, rkd = 1, dest = 5, gr_we = 1.
  - Response: next cycle es_to_ms_valid = 1, alu_result = 0x80000000, dest = 5, data_sram_en = 0.
- Shifts and compares, each issued back-to-back with ms_allowin = 1, one result per cycle, no bubbles:
  - srai: src1 = 0x80000000, imm = 0x21, expect 0xC0000000.
  - slt: src1 = 0xFFFFFFFF, src2 = 1, expect 1.
  - sltu: same operands, expect 0.
  - lu12i: imm = 0x12345000, expect 0x12345000.
- st.w:
  - Stimulus: rj = 0x1000, imm = 0xFFC, rkd = 0xDEADBEEF, mem_we = 1.
  - Response: data_sram_en = 1, we = 0xF, addr = 0x1FFC, wdata = 0xDEADBEEF.
  - ld.w with the same operands (res_from_mem = 1) gives the same address with we = 0.
- Backpressure:
  - Hold ms_allowin = 0 for 3 cycles with es_valid = 1 and ds_to_es_valid = 1.
  - Response: es_allowin = 0; the bus register, es_to_ms_bus and the SRAM outputs are unchanged.
  - On release, the new bundle loads in the same cycle.
- bl with PC source:
  - Stimulus: pc = 0x1C000008, src1_is_pc = 1, imm = 4, alu_op = add.
  - Response: alu_result = 0x1C00000C.
  - Then assert reset with an instruction resident -> es_to_ms_valid = 0 in the following cycle.

Source files
------------

// File: rtl/exe_stage.sv
// exe_stage: execute stage that registers the decoded bundle, runs the ALU and issues data-SRAM requests
module exe_stage (
    input  logic         clk,
    input  logic         reset,
    input  logic         ms_allowin,
    output logic         es_allowin,
    input  logic         ds_to_es_valid,
    input  logic [149:0] ds_to_es_bus,
    output logic         es_to_ms_valid,
    output logic [70:0]  es_to_ms_bus,
    output logic         data_sram_en,
    output logic [3:0]   data_sram_we,
    output logic [31:0]  data_sram_addr,
    output logic [31:0]  data_sram_wdata
);
    logic         es_valid_q, es_valid_d;
    logic [149:0] bus_q, bus_d;
    logic [11:0]  alu_op;
    logic         res_from_mem, src1_is_pc, src2_is_imm, gr_we, mem_we;
    logic [4:0]   dest, sh;
    logic [31:0]  imm, rj_value, rkd_value, pc, src1, src2, sra_res, alu_result;
    logic         es_ready_go;

    assign es_ready_go = 1'b1;
    assign es_allowin = !es_valid_q || (es_ready_go && ms_allowin);
    assign es_to_ms_valid = es_valid_q && es_ready_go;
    assign {alu_op, res_from_mem, src1_is_pc, src2_is_imm, gr_we, mem_we, dest,
            imm, rj_value, rkd_value, pc} = bus_q;
    assign src1 = src1_is_pc ? pc : rj_value;
    assign src2 = src2_is_imm ? imm : rkd_value;
    assign sh = src2[4:0];
    assign sra_res = $signed(src1) >>> sh;

    always_comb begin
        es_valid_d = es_allowin ? ds_to_es_valid : es_valid_q;
        bus_d = (ds_to_es_valid && es_allowin) ? ds_to_es_bus : bus_q;
        alu_result = alu_op[0]  ? src1 + src2 :
                     alu_op[1]  ? src1 - src2 :
                     alu_op[2]  ? {31'b0, $signed(src1) < $signed(src2)} :
                     alu_op[3]  ? {31'b0, src1 < src2} :
                     alu_op[4]  ? src1 & src2 :
                     alu_op[5]  ? ~(src1 | src2) :
                     alu_op[6]  ? src1 | src2 :
                     alu_op[7]  ? src1 ^ src2 :
                     alu_op[8]  ? src1 << sh :
                     alu_op[9]  ? src1 >> sh :
                     alu_op[10] ? sra_res :
                     alu_op[11] ? src2 : 32'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            es_valid_q <= 1'b0;
            bus_q      <= '0;
        end else begin
            es_valid_q <= es_valid_d;
            bus_q      <= bus_d;
        end
    end

    assign es_to_ms_bus    = {res_from_mem, gr_we, dest, alu_result, pc};
    assign data_sram_en    = es_valid_q && (res_from_mem || mem_we);
    assign data_sram_we    = (es_valid_q && mem_we) ? 4'hF : 4'h0;
    assign data_sram_addr  = alu_result;
    assign data_sram_wdata = rkd_value;
endmodule

// File: tb/tb_exe_stage.sv
// tb_exe_stage: directed self-checking bench for exe_stage
module tb_exe_stage;
    logic         clk = 1'b0, reset, ms_allowin, es_allowin, ds_to_es_valid;
    logic [149:0] ds_to_es_bus;
    logic         es_to_ms_valid, data_sram_en;
    logic [70:0]  es_to_ms_bus;
    logic [3:0]   data_sram_we;
    logic [31:0]  data_sram_addr, data_sram_wdata;
    int           nerr = 0, nchk = 0;

    localparam logic [11:0] ADD = 12'h001, SUB = 12'h002, SLT = 12'h004, SLTU = 12'h008,
                            NOR = 12'h020, XOR = 12'h080, SLL = 12'h100, SRL = 12'h200,
                            SRA = 12'h400, LUI = 12'h800;

    exe_stage dut (
        .clk(clk), .reset(reset), .ms_allowin(ms_allowin), .es_allowin(es_allowin),
        .ds_to_es_valid(ds_to_es_valid), .ds_to_es_bus(ds_to_es_bus),
        .es_to_ms_valid(es_to_ms_valid), .es_to_ms_bus(es_to_ms_bus),
        .data_sram_en(data_sram_en), .data_sram_we(data_sram_we),
        .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata)
    );

    always #5 clk = ~clk;

    function automatic logic [149:0] mk(input logic [11:0] op, input logic rfm, s1, s2, gw, mw,
                                        input logic [4:0] d, input logic [31:0] imm, rj, rkd, pc);
        return {op, rfm, s1, s2, gw, mw, d, imm, rj, rkd, pc};
    endfunction

    task automatic chk(input string tag, input logic [70:0] obs, input logic [70:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_res(input string tag, input logic [31:0] exp);
        chk({tag, "_valid"}, 71'(es_to_ms_valid), 71'(1'b1));
        chk(tag, 71'(es_to_ms_bus[63:32]), 71'(exp));
    endtask

    initial begin
        reset = 1'b1; ms_allowin = 1'b1; ds_to_es_valid = 1'b0; ds_to_es_bus = '0;
        cyc; cyc;
        chk("rst_valid", 71'(es_to_ms_valid), 71'(1'b0));
        chk("rst_en", 71'(data_sram_en), 71'(1'b0));
        chk("rst_we", 71'(data_sram_we), 71'(4'h0));
        chk("rst_allowin", 71'(es_allowin), 71'(1'b1));
        reset = 1'b0;
        ds_to_es_valid = 1'b1;
        ds_to_es_bus = mk(ADD, 0, 0, 0, 1, 0, 5'd5, 32'h0, 32'h7FFFFFFF, 32'h1, 32'h1C000000);
        cyc;
        chk_res("add", 32'h80000000);
        chk("add_dest", 71'(es_to_ms_bus[68:64]), 71'(5'd5));
        chk("add_grwe", 71'(es_to_ms_bus[69]), 71'(1'b1));
        chk("add_en", 71'(data_sram_en), 71'(1'b0));
        ds_to_es_bus = mk(SRA, 0, 0, 1, 1, 0, 5'd6, 32'h21, 32'h80000000, 32'h0, 32'h1C000004);
        cyc;
        chk_res("srai", 32'hC0000000);
        ds_to_es_bus = mk(SLT, 0, 0, 0, 1, 0, 5'd7, 32'h0, 32'hFFFFFFFF, 32'h1, 32'h1C000008);
        cyc;
        chk_res("slt", 32'h1);
        ds_to_es_bus = mk(SLTU, 0, 0, 0, 1, 0, 5'd8, 32'h0, 32'hFFFFFFFF, 32'h1, 32'h1C00000C);
        cyc;
        chk_res("sltu", 32'h0);
        ds_to_es_bus = mk(LUI, 0, 0, 1, 1, 0, 5'd9, 32'h12345000, 32'hAAAAAAAA, 32'h0, 32'h1C000010);
        cyc;
        chk_res("lu12i", 32'h12345000);
        ds_to_es_bus = mk(SUB, 0, 0, 0, 1, 0, 5'd1, 32'h0, 32'h5, 32'h7, 32'h0);
        cyc;
        chk_res("sub", 32'hFFFFFFFE);
        ds_to_es_bus = mk(NOR, 0, 0, 0, 1, 0, 5'd1, 32'h0, 32'hF0F00000, 32'h0000000F, 32'h0);
        cyc;
        chk_res("nor", 32'h0F0FFFF0);
        ds_to_es_bus = mk(SLL, 0, 0, 0, 1, 0, 5'd1, 32'h0, 32'h00000003, 32'hFFFFFFE4, 32'h0);
        cyc;
        chk_res("sll", 32'h00000030);
        ds_to_es_bus = mk(SRL, 0, 0, 0, 1, 0, 5'd1, 32'h0, 32'h80000000, 32'h0000003F, 32'h0);
        cyc;
        chk_res("srl", 32'h00000001);
        ds_to_es_bus = mk(12'h000, 0, 0, 0, 1, 0, 5'd1, 32'h0, 32'h1234, 32'h5678, 32'h0);
        cyc;
        chk_res("noop", 32'h0);
        ds_to_es_bus = mk(ADD, 0, 0, 1, 0, 1, 5'd0, 32'hFFC, 32'h1000, 32'hDEADBEEF, 32'h1C000020);
        cyc;
        chk("st_en", 71'(data_sram_en), 71'(1'b1));
        chk("st_we", 71'(data_sram_we), 71'(4'hF));
        chk("st_addr", 71'(data_sram_addr), 71'(32'h1FFC));
        chk("st_wdata", 71'(data_sram_wdata), 71'(32'hDEADBEEF));
        ds_to_es_bus = mk(ADD, 1, 0, 1, 1, 0, 5'd4, 32'hFFC, 32'h1000, 32'hDEADBEEF, 32'h1C000024);
        cyc;
        chk("ld_en", 71'(data_sram_en), 71'(1'b1));
        chk("ld_we", 71'(data_sram_we), 71'(4'h0));
        chk("ld_addr", 71'(data_sram_addr), 71'(32'h1FFC));
        chk("ld_rfm", 71'(es_to_ms_bus[70]), 71'(1'b1));
        ds_to_es_bus = mk(ADD, 0, 0, 1, 0, 1, 5'd0, 32'hFFC, 32'h1000, 32'hDEADBEEF, 32'h1C000028);
        cyc;
        ms_allowin = 1'b0;
        ds_to_es_bus = mk(XOR, 0, 0, 0, 1, 0, 5'd3, 32'h0, 32'hF0F0F0F0, 32'hFF00FF00, 32'h1C00002C);
        #1;
        chk("stall_allowin", 71'(es_allowin), 71'(1'b0));
        for (int i = 0; i < 3; i++) begin
            cyc;
            chk("stall_bus", es_to_ms_bus, {1'b0, 1'b0, 5'd0, 32'h1FFC, 32'h1C000028});
            chk("stall_valid", 71'(es_to_ms_valid), 71'(1'b1));
            chk("stall_sram", {33'b0, data_sram_en, data_sram_we, data_sram_wdata},
                {33'b0, 1'b1, 4'hF, 32'hDEADBEEF});
        end
        ms_allowin = 1'b1;
        #1;
        chk("release_allowin", 71'(es_allowin), 71'(1'b1));
        cyc;
        chk_res("xor", 32'h0FF00FF0);
        chk("xor_en", 71'(data_sram_en), 71'(1'b0));
        ds_to_es_valid = 1'b0;
        cyc;
        chk("drain_valid", 71'(es_to_ms_valid), 71'(1'b0));
        ds_to_es_valid = 1'b1;
        ds_to_es_bus = mk(ADD, 0, 1, 1, 1, 0, 5'd1, 32'h4, 32'h0, 32'h0, 32'h1C000008);
        cyc;
        chk_res("bl", 32'h1C00000C);
        chk("bl_pc", 71'(es_to_ms_bus[31:0]), 71'(32'h1C000008));
        ds_to_es_valid = 1'b0;
        ms_allowin = 1'b0;
        ds_to_es_bus = mk(ADD, 0, 0, 1, 0, 1, 5'd0, 32'h4, 32'h0, 32'h0, 32'h0);
        reset = 1'b1;
        cyc;
        chk("rst_mid_valid", 71'(es_to_ms_valid), 71'(1'b0));
        chk("rst_mid_en", 71'(data_sram_en), 71'(1'b0));
        chk("rst_mid_allowin", 71'(es_allowin), 71'(1'b1));
        reset = 1'b0;
        cyc;
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
